// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: shadow scoreboard of EXE/MEM/WB destinations, stall/flush,
// branch-operand forward selects and PC redirect. Optional perf counters under HAZARD_PERF_EN.
module hazard_ctrl #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int FSEL_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr_decode,
  input  logic              id_valid,
  input  logic              br_true,
  input  logic              mem_ready,
  output logic              stall_if,
  output logic              flush_id,
  output logic              flush_if,
  output logic [1:0]        pc_sel,
  output logic [FSEL_W-1:0] branch_a_sel,
  output logic [FSEL_W-1:0] branch_b_sel,
  output logic              pipe_freeze,
  output logic [1:0]        fsm_state
`ifdef HAZARD_PERF_EN
  ,
  output logic [XLEN-1:0]   stall_cnt,
  output logic [XLEN-1:0]   redirect_cnt
`endif
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [FSEL_W-1:0] FORWARD_SEL_EXE = FSEL_W'(0);
  localparam logic [FSEL_W-1:0] FORWARD_SEL_MEM = FSEL_W'(1);
  localparam logic [FSEL_W-1:0] FORWARD_SEL_WB  = FSEL_W'(2);

  typedef struct packed {
    logic [RADDR_W-1:0] rd;
    logic               we;
    logic               ld;
  } sb_entry_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_FREEZE = 2'd2
  } state_t;

  sb_entry_t sb_exe, sb_mem, sb_wb, dec_entry;
  state_t    state_q, state_d;

  logic [6:0]         opcode;
  logic [RADDR_W-1:0] rd_f, rs1_f, rs2_f;
  logic               uses_rs1, uses_rs2, is_ctrl, writes_rd;
  logic               a_exe, a_mem, a_wb, b_exe, b_mem, b_wb;
  logic               haz;
  logic               unused_instr;

  assign opcode = instr_decode[6:0];
  assign rd_f   = instr_decode[7 +: RADDR_W];
  assign rs1_f  = instr_decode[15 +: RADDR_W];
  assign rs2_f  = instr_decode[20 +: RADDR_W];
  assign unused_instr = ^{instr_decode[31:25], instr_decode[14:12]};

  assign uses_rs1  = !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
  assign uses_rs2  = (opcode == OPC_BRANCH) || (opcode == OPC_STORE) || (opcode == OPC_OP);
  assign is_ctrl   = (opcode == OPC_BRANCH) || (opcode == OPC_JALR);
  assign writes_rd = (rd_f != '0) &&
                     (opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL ||
                      opcode == OPC_JALR || opcode == OPC_LOAD || opcode == OPC_OPIMM ||
                      opcode == OPC_OP);

  assign dec_entry.rd = writes_rd ? rd_f : '0;
  assign dec_entry.we = writes_rd;
  assign dec_entry.ld = writes_rd && (opcode == OPC_LOAD);

  // x0 is filtered here so it can never create a hazard or a forward.
  function automatic logic hit(input logic use_src, input logic [RADDR_W-1:0] src,
                               input sb_entry_t e);
    return use_src && (src != '0) && e.we && (e.rd == src);
  endfunction

  // Control consumers read operands in decode, so they also wait on ALU results in EXE
  // and on loads still in MEM.
  function automatic logic src_haz(input logic ctrl, input logic exe_hit, input logic mem_hit,
                                   input logic exe_ld, input logic mem_ld);
    return ctrl ? (exe_hit || (mem_hit && mem_ld)) : (exe_hit && exe_ld);
  endfunction

  function automatic logic [FSEL_W-1:0] fwd_sel(input logic mem_hit, input logic wb_hit);
    if (mem_hit) return FORWARD_SEL_MEM;
    if (wb_hit)  return FORWARD_SEL_WB;
    return FORWARD_SEL_EXE;
  endfunction

  assign a_exe = hit(uses_rs1, rs1_f, sb_exe);
  assign a_mem = hit(uses_rs1, rs1_f, sb_mem);
  assign a_wb  = hit(uses_rs1, rs1_f, sb_wb);
  assign b_exe = hit(uses_rs2, rs2_f, sb_exe);
  assign b_mem = hit(uses_rs2, rs2_f, sb_mem);
  assign b_wb  = hit(uses_rs2, rs2_f, sb_wb);

  assign haz = id_valid &&
               (src_haz(is_ctrl, a_exe, a_mem, sb_exe.ld, sb_mem.ld) ||
                src_haz(is_ctrl, b_exe, b_mem, sb_exe.ld, sb_mem.ld));

  always_comb begin
    stall_if     = 1'b0;
    flush_id     = 1'b0;
    flush_if     = 1'b0;
    pc_sel       = 2'd0;
    pipe_freeze  = 1'b0;
    branch_a_sel = FORWARD_SEL_EXE;
    branch_b_sel = FORWARD_SEL_EXE;
    if (!rst) begin
      if (id_valid && is_ctrl && !haz) begin
        branch_a_sel = fwd_sel(a_mem, a_wb);
        branch_b_sel = fwd_sel(b_mem, b_wb);
      end
      if (!mem_ready) begin
        // Redirect is suppressed, not dropped: it is recomputed once memory releases.
        pipe_freeze = 1'b1;
        stall_if    = 1'b1;
      end else if (haz) begin
        stall_if = 1'b1;
        flush_id = 1'b1;
      end else if (id_valid) begin
        unique case (opcode)
          OPC_BRANCH: pc_sel = br_true ? 2'd1 : 2'd0;
          OPC_JAL:    pc_sel = 2'd2;
          OPC_JALR:   pc_sel = 2'd3;
          default:    pc_sel = 2'd0;
        endcase
        flush_if = (pc_sel != 2'd0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_exe <= '0;
      sb_mem <= '0;
      sb_wb  <= '0;
    end else if (mem_ready) begin
      sb_wb  <= sb_mem;
      sb_mem <= sb_exe;
      sb_exe <= (haz || !id_valid) ? '0 : dec_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:    if (!mem_ready) state_d = ST_FREEZE; else if (haz)  state_d = ST_STALL;
      ST_STALL:  if (!mem_ready) state_d = ST_FREEZE; else if (!haz) state_d = ST_RUN;
      ST_FREEZE: if (mem_ready)  state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  assign fsm_state = state_q;

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt    <= '0;
      redirect_cnt <= '0;
    end else begin
      if (mem_ready && haz) stall_cnt <= stall_cnt + XLEN'(1);
      if (flush_if)         redirect_cnt <= redirect_cnt + XLEN'(1);
    end
  end
`else
  logic [XLEN-1:0] unused_xlen;
  assign unused_xlen = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vector table for the multi-cycle scenarios, then randomized
// instruction streams checked against a distance-based model of the in-flight pipeline.
module tb_hazard_ctrl;

  localparam logic [6:0] LOAD = 7'b0000011, BR = 7'b1100011, JAL = 7'b1101111,
                         JALR = 7'b1100111, STORE = 7'b0100011, OP = 7'b0110011,
                         OPIMM = 7'b0010011, LUI = 7'b0110111, AUIPC = 7'b0010111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr_decode = '0;
  logic        id_valid = 1'b0, br_true = 1'b0, mem_ready = 1'b1;
  logic        stall_if, flush_id, flush_if, pipe_freeze;
  logic [1:0]  pc_sel, branch_a_sel, branch_b_sel, fsm_state;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, redirect_cnt;
`endif

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .instr_decode(instr_decode), .id_valid(id_valid),
    .br_true(br_true), .mem_ready(mem_ready), .stall_if(stall_if), .flush_id(flush_id),
    .flush_if(flush_if), .pc_sel(pc_sel), .branch_a_sel(branch_a_sel),
    .branch_b_sel(branch_b_sel), .pipe_freeze(pipe_freeze), .fsm_state(fsm_state)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Bundle order: stall_if, flush_id, flush_if, pc_sel, a_sel, b_sel, pipe_freeze.
  function automatic logic [9:0] pk(input logic st, input logic fid, input logic fif,
                                    input logic [1:0] pcs, input logic [1:0] a,
                                    input logic [1:0] b, input logic frz);
    return {st, fid, fif, pcs, a, b, frz};
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b0, rd, op};
  endfunction

  // Model: in-flight producers indexed by distance from decode (0=EXE, 1=MEM, 2=WB).
  typedef struct {
    logic [4:0] rd;
    bit         we;
    bit         ld;
  } ent_t;

  ent_t pipe_m[3];
  int   st_m = 0;
  int   stall_m = 0;
  int   redir_m = 0;

  function automatic int nearest(input logic [4:0] src);
    if (src == 5'd0) return -1;
    for (int i = 0; i < 3; i++)
      if (pipe_m[i].we && pipe_m[i].rd == src) return i;
    return -1;
  endfunction

  function automatic void model_eval(input logic [31:0] ins, input logic idv, input logic br,
                                     input logic mr, input logic rs,
                                     output logic [9:0] eo, output bit haz);
    logic [6:0] op;
    bit u1, u2, ctrl, h1, h2, fif;
    int d1, d2;
    logic [1:0] s1, s2, pcs;
    op   = ins[6:0];
    u1   = !(op == LUI || op == AUIPC || op == JAL);
    u2   = (op == BR || op == STORE || op == OP);
    ctrl = (op == BR || op == JALR);
    d1   = u1 ? nearest(ins[19:15]) : -1;
    d2   = u2 ? nearest(ins[24:20]) : -1;
    h1   = ctrl ? (d1 == 0 || (d1 == 1 && pipe_m[1].ld)) : (d1 == 0 && pipe_m[0].ld);
    h2   = ctrl ? (d2 == 0 || (d2 == 1 && pipe_m[1].ld)) : (d2 == 0 && pipe_m[0].ld);
    haz  = idv && (h1 || h2);
    s1 = 2'd0;
    s2 = 2'd0;
    if (idv && ctrl && !haz) begin
      s1 = (d1 == 1) ? 2'd1 : (d1 == 2) ? 2'd2 : 2'd0;
      s2 = (d2 == 1) ? 2'd1 : (d2 == 2) ? 2'd2 : 2'd0;
    end
    pcs = 2'd0;
    if (idv && op == BR && br) pcs = 2'd1;
    if (idv && op == JAL)      pcs = 2'd2;
    if (idv && op == JALR)     pcs = 2'd3;
    fif = (pcs != 2'd0);
    if (rs)        eo = '0;
    else if (!mr)  eo = pk(1, 0, 0, 2'd0, s1, s2, 1);
    else if (haz)  eo = pk(1, 1, 0, 2'd0, 2'd0, 2'd0, 0);
    else           eo = pk(0, 0, fif, pcs, s1, s2, 0);
  endfunction

  function automatic void model_clock(input logic [31:0] ins, input logic idv, input logic mr,
                                      input logic rs, input bit haz, input logic [9:0] eo);
    logic [6:0] op;
    ent_t n;
    op = ins[6:0];
    if (rs) begin
      for (int i = 0; i < 3; i++) pipe_m[i] = '{5'd0, 1'b0, 1'b0};
      st_m = 0;
      stall_m = 0;
      redir_m = 0;
      return;
    end
    if (mr && haz) stall_m++;
    if (eo[7])     redir_m++;
    st_m = !mr ? 2 : (st_m == 2) ? 0 : (haz ? 1 : 0);
    if (mr) begin
      n.rd = ins[11:7];
      n.we = idv && !haz && ins[11:7] != 5'd0 &&
             (op == LUI || op == AUIPC || op == JAL || op == JALR || op == LOAD ||
              op == OPIMM || op == OP);
      n.ld = (op == LOAD);
      pipe_m[2] = pipe_m[1];
      pipe_m[1] = pipe_m[0];
      pipe_m[0] = n;
    end
  endfunction

  task automatic step(input string tag, input logic [31:0] ins, input logic idv,
                      input logic br, input logic mr, input logic rs,
                      input bit use_exp, input logic [9:0] exp);
    logic [9:0] eo;
    bit haz;
    instr_decode = ins;
    id_valid     = idv;
    br_true      = br;
    mem_ready    = mr;
    rst          = rs;
    #2;
    model_eval(ins, idv, br, mr, rs, eo, haz);
    check({tag, " outputs"},
          {22'd0, stall_if, flush_id, flush_if, pc_sel, branch_a_sel, branch_b_sel, pipe_freeze},
          {22'd0, use_exp ? exp : eo});
    if (!rs) check({tag, " state"}, {30'd0, fsm_state}, st_m);
    @(posedge clk);
    #1;
    model_clock(ins, idv, mr, rs, haz, eo);
  endtask

  typedef struct {
    logic [31:0] ins;
    logic        idv, br, mr, rs;
    logic [9:0]  exp;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic [31:0] ins, input logic idv, input logic br, input logic mr,
                     input logic rs, input logic [9:0] exp);
    vt.push_back('{ins, idv, br, mr, rs, exp});
  endtask

  logic [6:0] ops [9] = '{LOAD, BR, JAL, JALR, STORE, OP, OPIMM, LUI, AUIPC};

  initial begin
    logic [31:0] ins;
    for (int i = 0; i < 3; i++) pipe_m[i] = '{5'd0, 1'b0, 1'b0};
    @(posedge clk);
    #1;

    // reset with memory stalled: reset wins, every output low
    add(mk(OP, 6, 5, 2),     1, 0, 0, 1, '0);
    add(mk(OPIMM, 0, 0, 0),  1, 0, 1, 1, '0);
    // load-use
    add(mk(LOAD, 5, 1, 0),   1, 0, 1, 0, '0);
    add(mk(OP, 6, 5, 2),     1, 0, 1, 0, pk(1, 1, 0, 0, 0, 0, 0));
    add(mk(OP, 6, 5, 2),     1, 0, 1, 0, '0);
    // ALU producer feeding a branch
    add(mk(OPIMM, 5, 0, 1),  1, 0, 1, 0, '0);
    add(mk(BR, 0, 5, 0),     1, 0, 1, 0, pk(1, 1, 0, 0, 0, 0, 0));
    add(mk(BR, 0, 5, 0),     1, 0, 1, 0, pk(0, 0, 0, 0, 1, 0, 0));
    // load feeding a taken branch
    add(mk(LOAD, 7, 0, 0),   1, 0, 1, 0, '0);
    add(mk(BR, 0, 7, 7),     1, 1, 1, 0, pk(1, 1, 0, 0, 0, 0, 0));
    add(mk(BR, 0, 7, 7),     1, 1, 1, 0, pk(1, 1, 0, 0, 0, 0, 0));
    add(mk(BR, 0, 7, 7),     1, 1, 1, 0, pk(0, 0, 1, 1, 2, 2, 0));
    // JAL held across a 3-cycle freeze
    add(mk(JAL, 1, 0, 0),    1, 0, 0, 0, pk(1, 0, 0, 0, 0, 0, 1));
    add(mk(JAL, 1, 0, 0),    1, 0, 0, 0, pk(1, 0, 0, 0, 0, 0, 1));
    add(mk(JAL, 1, 0, 0),    1, 0, 0, 0, pk(1, 0, 0, 0, 0, 0, 1));
    add(mk(JAL, 1, 0, 0),    1, 0, 1, 0, pk(0, 0, 1, 2, 0, 0, 0));
    // x0 never hazards
    add(mk(OPIMM, 0, 0, 5),  1, 0, 1, 0, '0);
    add(mk(BR, 0, 0, 0),     1, 0, 1, 0, '0);
    // reset in the middle of a load stall
    add(mk(LOAD, 8, 0, 0),   1, 0, 1, 0, '0);
    add(mk(BR, 0, 8, 0),     1, 0, 1, 0, pk(1, 1, 0, 0, 0, 0, 0));
    add(mk(BR, 0, 8, 0),     1, 0, 1, 1, '0);
    add(mk(BR, 0, 8, 0),     1, 0, 1, 0, '0);
    // invalid decode slot ignored
    add(mk(OP, 6, 5, 2),     0, 0, 1, 0, '0);
    // JALR base forwarded from WB
    add(mk(OPIMM, 3, 0, 0),  1, 0, 1, 0, '0);
    add(mk(OP, 4, 0, 0),     1, 0, 1, 0, '0);
    add(mk(OP, 9, 0, 0),     1, 0, 1, 0, '0);
    add(mk(JALR, 1, 3, 0),   1, 0, 1, 0, pk(0, 0, 1, 3, 2, 0, 0));

    for (int i = 0; i < vt.size(); i++)
      step($sformatf("vec%0d", i), vt[i].ins, vt[i].idv, vt[i].br, vt[i].mr, vt[i].rs,
           1'b1, vt[i].exp);

    step("rnd_reset", mk(OPIMM, 0, 0, 0), 1, 0, 1, 1, 1'b0, '0);
    for (int i = 0; i < 600; i++) begin
      ins = $urandom;
      ins[6:0]   = ops[$urandom_range(0, 8)];
      ins[11:7]  = 5'($urandom_range(0, 3));
      ins[19:15] = 5'($urandom_range(0, 3));
      ins[24:20] = 5'($urandom_range(0, 3));
      step($sformatf("rnd%0d", i), ins, 1'($urandom_range(0, 9) != 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 6) != 0),
           1'($urandom_range(0, 59) == 0), 1'b0, '0);
    end

`ifdef HAZARD_PERF_EN
    check("stall_cnt", stall_cnt, stall_m);
    check("redirect_cnt", redirect_cnt, redir_m);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
